// File: rtl/usb_transmitter_if.sv
// usb_transmitter_if: byte-stream handshake feeding the USB transmitter.
interface usb_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_last, tx_valid, input tx_ready);
    modport slave (input tx_data, tx_last, tx_valid, output tx_ready);
endinterface

// File: rtl/usb_transmitter.sv
// usb_transmitter: full-speed USB line transmitter sending SYNC, NRZI bit-stuffed bytes, then EOP.
// Define USB_TX_CRC16_EN to append the complemented CRC16 of the bytes after the PID.
module usb_transmitter #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int STUFF_LIMIT    = 6
) (
    input  logic             clock48,
    input  logic             reset_n,
    usb_transmitter_if.slave tx,
    output logic             usb_d_p_out,
    output logic             usb_d_n_out,
    output logic             usb_oe,
    output logic             busy,
    output logic             underrun
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int SW = $clog2(STUFF_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [SW-1:0] SLIM = SW'(STUFF_LIMIT);

    typedef enum logic [2:0] {
        IDLE, SYNC, DATA, EOP
`ifdef USB_TX_CRC16_EN
        , CRC
`endif
    } state_t;

    state_t          state, state_d, tail;
    logic [CW-1:0]   cnt, cnt_d;
    logic [3:0]      idx, idx_d, top;
    logic [SW-1:0]   ones, ones_d;
    logic            stf, stf_d, fin, fin_d;
    logic [7:0]      data_q, data_d;
    logic            last_q, last_d, pid_q, pid_d;
    logic            dp_d, dn_d, oe_d, busy_d, und_d;
    logic            tick, start, fetch, bit_v;
`ifdef USB_TX_CRC16_EN
    logic [15:0]     crc_q, crc_d;
    logic            need_q, need_d;
`endif

    assign tick  = cnt == LAST;
    assign start = cnt == '0;
    assign fetch = state == DATA && tick && idx == 4'd7 && !stf && !last_q;
    assign tx.tx_ready = reset_n && (state == IDLE || fetch);
`ifdef USB_TX_CRC16_EN
    assign top   = state == CRC ? 4'd15 : 4'd7;
    assign tail  = state == DATA && need_q ? CRC : EOP;
    assign bit_v = !stf && (state == SYNC ? idx == 4'd7 :
                            state == DATA ? data_q[idx[2:0]] : state == CRC && !crc_q[idx]);
`else
    assign top   = 4'd7;
    assign tail  = EOP;
    assign bit_v = !stf && (state == SYNC ? idx == 4'd7 : state == DATA && data_q[idx[2:0]]);
`endif

    // The line register is loaded at the first clock of each internal bit slot,
    // so the pads trail the internal slot by one cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        ones_d  = ones;
        stf_d   = stf;
        fin_d   = fin;
        data_d  = data_q;
        last_d  = last_q;
        pid_d   = pid_q;
        dp_d    = usb_d_p_out;
        dn_d    = usb_d_n_out;
        oe_d    = usb_oe;
        busy_d  = busy;
        und_d   = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_d   = crc_q;
        need_d  = need_q;
`endif
        if (state == IDLE) begin
            if (tx.tx_valid && tx.tx_ready) begin
                state_d = SYNC;
                cnt_d   = CW'(1);
                idx_d   = '0;
                ones_d  = '0;
                stf_d   = 1'b0;
                fin_d   = 1'b0;
                data_d  = tx.tx_data;
                last_d  = tx.tx_last;
                pid_d   = 1'b1;
                dp_d    = 1'b0;
                dn_d    = 1'b1;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
`ifdef USB_TX_CRC16_EN
                crc_d   = 16'hFFFF;
                need_d  = !tx.tx_last || &tx.tx_data[1:0];
`endif
            end
        end else if (state == EOP) begin
            cnt_d = tick ? '0 : cnt + 1'b1;
            if (start) begin
                dp_d = idx[1];
                dn_d = 1'b0;
                if (idx == 4'd3) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            if (tick) idx_d = idx + 4'd1;
        end else begin
            cnt_d = tick ? '0 : cnt + 1'b1;
            if (start) begin
                dp_d   = bit_v ? usb_d_p_out : ~usb_d_p_out;
                dn_d   = bit_v ? usb_d_n_out : ~usb_d_n_out;
                ones_d = bit_v ? ones + 1'b1 : '0;
`ifdef USB_TX_CRC16_EN
                if (state == DATA && !stf && !pid_q)
                    crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_v) ? 16'hA001 : 16'h0000);
`endif
            end
            if (tick) begin
                stf_d = ones == SLIM;
                if (stf) begin
                    if (fin) begin
                        state_d = tail;
                        idx_d   = '0;
                        fin_d   = 1'b0;
                    end
                end else if (state == SYNC) begin
                    idx_d = idx + 4'd1;
                    if (idx == 4'd7) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else if (idx == top) begin
                    if (fetch && tx.tx_valid) begin
                        data_d = tx.tx_data;
                        last_d = tx.tx_last;
                        pid_d  = 1'b0;
                        idx_d  = '0;
                    end else if (fetch) begin
                        und_d   = 1'b1;
                        state_d = EOP;
                        idx_d   = '0;
                        stf_d   = 1'b0;
                    end else if (ones == SLIM) begin
                        fin_d = 1'b1;
                    end else begin
                        state_d = tail;
                        idx_d   = '0;
                    end
                end else begin
                    idx_d = idx + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            ones        <= '0;
            stf         <= 1'b0;
            fin         <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            pid_q       <= 1'b0;
            usb_d_p_out <= 1'b1;
            usb_d_n_out <= 1'b0;
            usb_oe      <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q       <= 16'hFFFF;
            need_q      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            ones        <= ones_d;
            stf         <= stf_d;
            fin         <= fin_d;
            data_q      <= data_d;
            last_q      <= last_d;
            pid_q       <= pid_d;
            usb_d_p_out <= dp_d;
            usb_d_n_out <= dn_d;
            usb_oe      <= oe_d;
            busy        <= busy_d;
            underrun    <= und_d;
`ifdef USB_TX_CRC16_EN
            crc_q       <= crc_d;
            need_q      <= need_d;
`endif
        end
    end
endmodule

// File: tb/tb_usb_transmitter.sv
// tb_usb_transmitter: directed packets for usb_transmitter with hand-written line symbol strings.
module tb_usb_transmitter;
    logic clock48 = 1'b0;
    logic reset_n = 1'b0;
    logic usb_d_p_out, usb_d_n_out, usb_oe, busy, underrun;
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] s_t [0:255];
    logic oe_t [0:255];
    logic busy_t [0:255];
    logic rdy_t [0:255];
    logic und_t [0:255];
    logic [7:0] q_data [$];
    logic q_last [$];

    usb_transmitter_if bus ();

    usb_transmitter dut (
        .clock48(clock48),
        .reset_n(reset_n),
        .tx(bus.slave),
        .usb_d_p_out(usb_d_p_out),
        .usb_d_n_out(usb_d_n_out),
        .usb_oe(usb_oe),
        .busy(busy),
        .underrun(underrun)
    );

    always #5 clock48 = ~clock48;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_byte;
        if (q_data.size() == 0) begin
            bus.tx_valid = 1'b0;
        end else begin
            bus.tx_data = q_data.pop_front();
            bus.tx_last = q_last.pop_front();
        end
    endtask

    // Cycle 0 is the acceptance cycle; samples k=1..n are taken on the falling edge of cycle k.
    task automatic run(input int n);
        int w;
        w = 0;
        bus.tx_data  = q_data.pop_front();
        bus.tx_last  = q_last.pop_front();
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && w < 20) begin
            @(negedge clock48);
            w++;
        end
        check("accept", 32'(w < 20), 1);
        @(posedge clock48);
        #1;
        next_byte();
        for (int k = 1; k <= n; k++) begin
            @(negedge clock48);
            s_t[k]    = {usb_d_p_out, usb_d_n_out};
            oe_t[k]   = usb_oe;
            busy_t[k] = busy;
            rdy_t[k]  = bus.tx_ready;
            und_t[k]  = underrun;
            if (bus.tx_ready && bus.tx_valid) begin
                @(posedge clock48);
                #1;
                next_byte();
            end
        end
    endtask

    task automatic check_pkt(input string name, input string exp, input int rdy_at, input int und_at);
        int len;
        int c_oe, c_busy, c_rdy, c_und;
        logic [1:0] e;
        len = exp.len() * 4;
        c_oe = 0; c_busy = 0; c_rdy = 0; c_und = 0;
        for (int i = 0; i < exp.len(); i++) begin
            e = exp[i] == "J" ? 2'b10 : exp[i] == "K" ? 2'b01 : 2'b00;
            check($sformatf("%s_sym%0d", name, i),
                  {s_t[4*i+1], s_t[4*i+2], s_t[4*i+3], s_t[4*i+4]}, {4{e}});
        end
        for (int k = 1; k <= len; k++) begin
            c_oe   += int'(oe_t[k]);
            c_busy += int'(busy_t[k]);
            c_rdy  += int'(rdy_t[k]);
            c_und  += int'(und_t[k]);
        end
        check({name, "_oe_cycles"}, c_oe, len);
        check({name, "_oe_after"}, oe_t[len+1], 0);
        check({name, "_busy_cycles"}, c_busy, len);
        check({name, "_busy_after"}, busy_t[len+1], 0);
        check({name, "_ready_count"}, c_rdy, rdy_at > 0 ? 1 : 0);
        check({name, "_underrun_count"}, c_und, und_at > 0 ? 1 : 0);
        if (rdy_at > 0) check({name, "_ready_slot"}, rdy_t[rdy_at], 1);
        if (und_at > 0) check({name, "_underrun_slot"}, und_t[und_at], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clock48);
        check("rst_oe", usb_oe, 0);
        check("rst_dp", usb_d_p_out, 1);
        check("rst_dn", usb_d_n_out, 0);
        check("rst_ready", bus.tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        #1;
        check("ready_after_rst", bus.tx_ready, 1);
        @(negedge clock48);

        q_data.push_back(8'hD2); q_last.push_back(1'b1);
        run(80);
        check_pkt("ack", "KJKJKJKKJJKJJKKK00J", 0, 0);

        q_data.push_back(8'hFF); q_last.push_back(1'b1);
        run(84);
        check_pkt("ff", "KJKJKJKKKKKKKJJJJ00J", 0, 0);

        q_data.push_back(8'h01); q_last.push_back(1'b0);
        q_data.push_back(8'h02); q_last.push_back(1'b1);
        run(112);
        check_pkt("two", "KJKJKJKKKJKJKJKJKKJKJKJK00J", 63, 0);

        q_data.push_back(8'h01); q_last.push_back(1'b0);
        run(80);
        check_pkt("starve", "KJKJKJKKKJKJKJKJ00J", 63, 64);

        q_data.push_back(8'hD2); q_last.push_back(1'b1);
        run(80);
        check_pkt("ack2", "KJKJKJKKJJKJJKKK00J", 0, 0);

        q_data.push_back(8'h55); q_last.push_back(1'b1);
        run(50);
        check("pre_rst_oe", usb_oe, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_oe", usb_oe, 0);
        check("mid_rst_dp", usb_d_p_out, 1);
        check("mid_rst_dn", usb_d_n_out, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clock48);
        reset_n = 1'b1;
        @(negedge clock48);

        q_data.push_back(8'hD2); q_last.push_back(1'b1);
        run(80);
        check_pkt("ack3", "KJKJKJKKJJKJJKKK00J", 0, 0);

        q_data.push_back(8'hC3); q_last.push_back(1'b1);
`ifdef USB_TX_CRC16_EN
        run(144);
        check_pkt("data0", "KJKJKJKKKKJKJKKKJKJKJKJKJKJKJKJK00J", 0, 0);
`else
        run(80);
        check_pkt("data0", "KJKJKJKKKKJKJKKK00J", 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
